mode_storage: RTL and testbench

MODE_STORAGE -- requirements
Module: mode_storage

---
 rtl/mode_storage.sv | 181 ++++++++++++++++++
 tb/tb_mode_storage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mode_storage.sv
// Mode-switchable storage: pass-through buffer, LIFO stack or FIFO queue over one memory.
// Define ERR_STICKY_EN to add the sticky overflow/underflow flag on port err.
module mode_storage #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 mode,
   input  logic [1:0]                 op,
   input  logic [DATA_W-1:0]          data_in,
   output logic [DATA_W-1:0]          data_out,
   output logic                       valid_out,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
`ifdef ERR_STICKY_EN
   ,
   output logic                       err
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      MODE_BUFFER  = 2'd0,
      MODE_LIFO    = 2'd1,
      MODE_FIFO    = 2'd2,
      MODE_INVALID = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      OP_NIMIC    = 2'd0,
      OP_PUSH     = 2'd1,
      OP_POP      = 2'd2,
      OP_PUSH_POP = 2'd3
   } op_e;

   logic [DATA_W-1:0] mem [DEPTH];

   mode_e             cur_mode, mode_n, mode_i;
   op_e               op_i;
   logic [AW-1:0]     wr_ptr, wr_n, rd_ptr, rd_n;
   logic [AW-1:0]     top, top_m1, waddr;
   logic [CW-1:0]     cnt_n;
   logic [DATA_W-1:0] dout_n;
   logic              vld_n, we, mode_chg;

   assign mode_i   = mode_e'(mode);
   assign op_i     = op_e'(op);
   assign mode_chg = (mode_i != cur_mode);
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   // Stack slot indices wrap naturally: top is only written when not full.
   assign top      = count[AW-1:0];
   assign top_m1   = top - AW'(1);

   always_comb begin
      mode_n = cur_mode;
      cnt_n  = count;
      wr_n   = wr_ptr;
      rd_n   = rd_ptr;
      dout_n = data_out;
      vld_n  = 1'b0;
      we     = 1'b0;
      waddr  = '0;
      if (mode_chg) begin
         mode_n = mode_i;
         cnt_n  = '0;
         wr_n   = '0;
         rd_n   = '0;
      end else begin
         unique case (cur_mode)
            MODE_BUFFER: begin
               if (op_i == OP_PUSH || op_i == OP_PUSH_POP) begin
                  dout_n = data_in;
                  vld_n  = 1'b1;
               end
            end
            MODE_FIFO: begin
               unique case (op_i)
                  OP_PUSH: if (!full) begin
                     we    = 1'b1;
                     waddr = wr_ptr;
                     wr_n  = wr_ptr + AW'(1);
                     cnt_n = count + CW'(1);
                  end
                  OP_POP: if (!empty) begin
                     dout_n = mem[rd_ptr];
                     vld_n  = 1'b1;
                     rd_n   = rd_ptr + AW'(1);
                     cnt_n  = count - CW'(1);
                  end
                  OP_PUSH_POP: begin
                     // When full wr_ptr == rd_ptr: the read sees the old word before the write lands.
                     we    = 1'b1;
                     waddr = wr_ptr;
                     wr_n  = wr_ptr + AW'(1);
                     if (empty) begin
                        cnt_n = count + CW'(1);
                     end else begin
                        dout_n = mem[rd_ptr];
                        vld_n  = 1'b1;
                        rd_n   = rd_ptr + AW'(1);
                     end
                  end
                  default: ;
               endcase
            end
            MODE_LIFO: begin
               unique case (op_i)
                  OP_PUSH: if (!full) begin
                     we    = 1'b1;
                     waddr = top;
                     cnt_n = count + CW'(1);
                  end
                  OP_POP: if (!empty) begin
                     dout_n = mem[top_m1];
                     vld_n  = 1'b1;
                     cnt_n  = count - CW'(1);
                  end
                  OP_PUSH_POP: begin
                     we = 1'b1;
                     if (empty) begin
                        waddr = top;
                        cnt_n = count + CW'(1);
                     end else begin
                        waddr  = top_m1;
                        dout_n = mem[top_m1];
                        vld_n  = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_mode  <= MODE_INVALID;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
      end else begin
         cur_mode  <= mode_n;
         count     <= cnt_n;
         wr_ptr    <= wr_n;
         rd_ptr    <= rd_n;
         data_out  <= dout_n;
         valid_out <= vld_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && we) begin
         mem[waddr] <= data_in;
      end
   end

`ifdef ERR_STICKY_EN
   logic fault;

   assign fault = !mode_chg && (cur_mode == MODE_FIFO || cur_mode == MODE_LIFO) &&
                  ((op_i == OP_PUSH && full) || (op_i == OP_POP && empty));

   always_ff @(posedge clk) begin
      if (rst || mode_chg) begin
         err <= 1'b0;
      end else if (fault) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mode_storage.sv
// Directed self-checking bench for mode_storage (default 8x8); checks err when ERR_STICKY_EN is defined.
module tb_mode_storage;

   localparam logic [1:0] M_BUF = 2'd0, M_LIFO = 2'd1, M_FIFO = 2'd2, M_INV = 2'd3;
   localparam logic [1:0] NOP = 2'd0, PUSH = 2'd1, POP = 2'd2, PP = 2'd3;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode, op;
   logic [7:0] data_in, data_out;
   logic       valid_out, full, empty;
   logic [3:0] count;
`ifdef ERR_STICKY_EN
   logic       err;
`endif

   int checks = 0;
   int errors = 0;

   mode_storage #(.DATA_W(8), .DEPTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .op        (op),
      .data_in   (data_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .full      (full),
      .empty     (empty),
      .count     (count)
`ifdef ERR_STICKY_EN
      ,
      .err       (err)
`endif
   );

   always #5 clk = ~clk;

   task automatic step(input logic [1:0] m, input logic [1:0] o, input logic [7:0] d);
      mode    = m;
      op      = o;
      data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_err(input string tag, input logic exp);
`ifdef ERR_STICKY_EN
      chk(tag, 32'(err), 32'(exp));
`else
      if (exp === 1'bx) $display("unused %s", tag);
`endif
   endtask

   initial begin
      logic [7:0] v;

      // Reset overrides a FIFO push request
      rst = 1'b1;
      step(M_FIFO, PUSH, 8'hEE);
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_valid", 32'(valid_out), 0);
      chk("rst_dout", 32'(data_out), 0);
      chk_err("rst_err", 1'b0);
      rst = 1'b0;

      // First edge after reset is a mode change: push ignored
      step(M_FIFO, PUSH, 8'h99);
      chk("chg_ignore_count", 32'(count), 0);
      chk("chg_ignore_valid", 32'(valid_out), 0);
      step(M_FIFO, NOP, 8'h00);

      // FIFO order
      step(M_FIFO, PUSH, 8'h11);
      step(M_FIFO, PUSH, 8'h22);
      step(M_FIFO, PUSH, 8'h33);
      chk("fifo_count3", 32'(count), 3);
      step(M_FIFO, POP, 8'h00);
      chk("fifo_pop1_v", 32'(valid_out), 1);
      chk("fifo_pop1_d", 32'(data_out), 32'h11);
      step(M_FIFO, POP, 8'h00);
      chk("fifo_pop2_d", 32'(data_out), 32'h22);
      step(M_FIFO, POP, 8'h00);
      chk("fifo_pop3_v", 32'(valid_out), 1);
      chk("fifo_pop3_d", 32'(data_out), 32'h33);
      step(M_FIFO, NOP, 8'h00);
      chk("fifo_idle_v", 32'(valid_out), 0);
      chk("fifo_hold_d", 32'(data_out), 32'h33);
      chk("fifo_empty", 32'(empty), 1);
      step(M_FIFO, POP, 8'h00);
      chk("fifo_under_v", 32'(valid_out), 0);
      chk("fifo_under_cnt", 32'(count), 0);
      chk_err("fifo_under_err", 1'b1);

      // LIFO order and push_pop
      step(M_LIFO, NOP, 8'h00);
      chk_err("lifo_chg_err", 1'b0);
      step(M_LIFO, PUSH, 8'hA1);
      step(M_LIFO, PUSH, 8'hA2);
      step(M_LIFO, PUSH, 8'hA3);
      step(M_LIFO, POP, 8'h00);
      chk("lifo_pop1_d", 32'(data_out), 32'hA3);
      step(M_LIFO, POP, 8'h00);
      chk("lifo_pop2_d", 32'(data_out), 32'hA2);
      step(M_LIFO, POP, 8'h00);
      chk("lifo_pop3_d", 32'(data_out), 32'hA1);
      chk("lifo_pop3_v", 32'(valid_out), 1);
      step(M_LIFO, PUSH, 8'hA1);
      step(M_LIFO, PP, 8'h55);
      chk("lifo_pp_d", 32'(data_out), 32'hA1);
      chk("lifo_pp_v", 32'(valid_out), 1);
      chk("lifo_pp_cnt", 32'(count), 1);
      step(M_LIFO, POP, 8'h00);
      chk("lifo_top_d", 32'(data_out), 32'h55);
      step(M_LIFO, PP, 8'h66);
      chk("lifo_pp_empty_v", 32'(valid_out), 0);
      chk("lifo_pp_empty_cnt", 32'(count), 1);

      // FIFO fill, overflow, drain past empty
      step(M_FIFO, NOP, 8'h00);
      for (int i = 1; i <= 8; i++) step(M_FIFO, PUSH, 8'(i));
      chk("ovf_full_pre", 32'(full), 1);
      step(M_FIFO, PUSH, 8'hFF);
      chk("ovf_full", 32'(full), 1);
      chk("ovf_count", 32'(count), 8);
      chk_err("ovf_err", 1'b1);
      for (int i = 1; i <= 10; i++) begin
         step(M_FIFO, POP, 8'h00);
         if (i <= 8) begin
            chk("drain_v", 32'(valid_out), 1);
            chk("drain_d", 32'(data_out), 32'(i));
         end else begin
            chk("drain_under_v", 32'(valid_out), 0);
            chk("drain_under_d", 32'(data_out), 32'h08);
         end
      end
      chk("drain_empty", 32'(empty), 1);

      // Pointer wrap: pointers start at 0, second batch crosses 7 -> 0
      for (int i = 0; i < 6; i++) step(M_FIFO, PUSH, 8'(8'h20 + i));
      for (int i = 0; i < 6; i++) begin
         step(M_FIFO, POP, 8'h00);
         chk("wrap1_d", 32'(data_out), 32'(8'h20 + i));
      end
      for (int i = 0; i < 6; i++) step(M_FIFO, PUSH, 8'(8'h30 + i));
      chk("wrap_count6", 32'(count), 6);
      for (int i = 0; i < 6; i++) begin
         step(M_FIFO, POP, 8'h00);
         v = 8'(8'h30 + i);
         chk("wrap2_d", 32'(data_out), 32'(v));
      end
      chk("wrap_count0", 32'(count), 0);

      // FIFO push_pop, non-empty and empty
      step(M_FIFO, PUSH, 8'h40);
      step(M_FIFO, PP, 8'h41);
      chk("fifo_pp_d", 32'(data_out), 32'h40);
      chk("fifo_pp_cnt", 32'(count), 1);
      step(M_FIFO, POP, 8'h00);
      chk("fifo_pp_next", 32'(data_out), 32'h41);
      step(M_FIFO, PP, 8'h42);
      chk("fifo_pp_empty_v", 32'(valid_out), 0);
      chk("fifo_pp_empty_cnt", 32'(count), 1);
      step(M_FIFO, POP, 8'h00);
      chk("fifo_pp_empty_d", 32'(data_out), 32'h42);

      // Mode change flushes, then BUFFER pass-through
      step(M_LIFO, NOP, 8'h00);
      step(M_LIFO, PUSH, 8'hB1);
      step(M_LIFO, PUSH, 8'hB2);
      step(M_LIFO, PUSH, 8'hB3);
      step(M_LIFO, POP, 8'h00);
      step(M_LIFO, POP, 8'h00);
      step(M_LIFO, POP, 8'h00);
      step(M_LIFO, POP, 8'h00);
      chk_err("lifo_under_err", 1'b1);
      step(M_LIFO, PUSH, 8'hB1);
      step(M_LIFO, PUSH, 8'hB2);
      step(M_LIFO, PUSH, 8'hB3);
      chk("lifo_cnt3", 32'(count), 3);
      step(M_FIFO, POP, 8'h00);
      chk("flush_count", 32'(count), 0);
      chk("flush_empty", 32'(empty), 1);
      chk("flush_valid", 32'(valid_out), 0);
      chk_err("flush_err", 1'b0);
      step(M_BUF, NOP, 8'h00);
      step(M_BUF, PUSH, 8'h7E);
      chk("buf_d", 32'(data_out), 32'h7E);
      chk("buf_v", 32'(valid_out), 1);
      chk("buf_cnt", 32'(count), 0);
      step(M_BUF, POP, 8'h00);
      chk("buf_pop_v", 32'(valid_out), 0);
      chk("buf_pop_d", 32'(data_out), 32'h7E);
      step(M_BUF, PP, 8'h3C);
      chk("buf_pp_d", 32'(data_out), 32'h3C);

      // INVALID ignores everything
      step(M_INV, PUSH, 8'h01);
      step(M_INV, PUSH, 8'h02);
      chk("inv_v", 32'(valid_out), 0);
      chk("inv_d", 32'(data_out), 32'h3C);
      chk("inv_cnt", 32'(count), 0);

      // Reset mid-operation
      step(M_FIFO, NOP, 8'h00);
      for (int i = 0; i < 4; i++) step(M_FIFO, PUSH, 8'(8'hC0 + i));
      chk("pre_rst_cnt", 32'(count), 4);
      rst = 1'b1;
      step(M_FIFO, PUSH, 8'hDD);
      chk("mid_rst_cnt", 32'(count), 0);
      chk("mid_rst_d", 32'(data_out), 0);
      chk("mid_rst_v", 32'(valid_out), 0);
      rst = 1'b0;
      step(M_FIFO, PUSH, 8'hDE);
      chk("post_rst_chg_cnt", 32'(count), 0);
      step(M_FIFO, PUSH, 8'hC9);
      step(M_FIFO, POP, 8'h00);
      chk("post_rst_d", 32'(data_out), 32'hC9);
      chk("post_rst_empty", 32'(empty), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
